// File: rtl/chunk_transfer_ctrl.sv
// Chunk sequencer: DDR load stream -> BRAM, compute handoff, BRAM -> DDR store stream.
// Optional macro CHUNK_LOAD_CHECKSUM_EN adds a 32-bit sum of all words accepted in LOAD.
module chunk_transfer_ctrl #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 12,
  parameter int CHUNK_WORDS = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] ddr_rd_data,
  input  logic              ddr_rd_valid,
  output logic              ddr_rd_ready,
  output logic [DATA_W-1:0] ddr_wr_data,
  output logic              ddr_wr_valid,
  input  logic              ddr_wr_ready,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] bram_din,
  output logic [ADDR_W-1:0] DDR_addr,
  output logic              wen,
  output logic              chunk_transfer_ready,
  output logic              chunk_compute_ready,
  output logic              compute_start,
  input  logic              compute_done,
  output logic              busy,
  output logic              chunk_done,
  output logic [15:0]       chunk_count
`ifdef CHUNK_LOAD_CHECKSUM_EN
  ,output logic [31:0]      load_checksum
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    COMPUTE = 3'd2,
    STORE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // One extra bit so a chunk of exactly 2^ADDR_W words still terminates.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(CHUNK_WORDS - 1);

  state_t            state;
  logic [ADDR_W:0]   ld_cnt;
  logic [ADDR_W:0]   rd_cnt;
  logic [ADDR_W:0]   wr_cnt;
  logic              p1;
  logic [DATA_W-1:0] fifo_mem [0:2];
  logic [1:0]        fifo_wp;
  logic [1:0]        fifo_rp;
  logic [1:0]        fifo_count;
  logic              ld_acc;
  logic              issue;
  logic              pop;

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    ld_acc = (state == LOAD) && ddr_rd_valid;
    // Reads in flight (p1) count against FIFO space so a push never overflows.
    issue  = (state == STORE) && (rd_cnt <= LAST_IDX) &&
             (({1'b0, fifo_count} + {2'b00, p1}) < 3'd3);
    pop    = ddr_wr_valid && ddr_wr_ready;
  end

  always_comb begin
    ddr_rd_ready = 1'b0;
    wen          = 1'b0;
    bram_din     = '0;
    DDR_addr     = '0;
    case (state)
      LOAD: begin
        ddr_rd_ready = 1'b1;
        wen          = ddr_rd_valid;
        bram_din     = ddr_rd_data;
        DDR_addr     = ld_cnt[ADDR_W-1:0];
      end
      STORE: begin
        DDR_addr = rd_cnt[ADDR_W-1:0];
      end
      default: begin
        DDR_addr = '0;
      end
    endcase
  end

  assign ddr_wr_valid         = (fifo_count != 2'd0);
  assign ddr_wr_data          = ddr_wr_valid ? fifo_mem[fifo_rp] : '0;
  assign chunk_transfer_ready = (state == LOAD) || (state == STORE);
  assign chunk_compute_ready  = (state == COMPUTE);
  assign busy                 = (state != IDLE);
  assign chunk_done           = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      ld_cnt        <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      compute_start <= 1'b0;
      chunk_count   <= 16'd0;
`ifdef CHUNK_LOAD_CHECKSUM_EN
      load_checksum <= 32'd0;
`endif
    end else begin
      compute_start <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= LOAD;
            ld_cnt <= '0;
`ifdef CHUNK_LOAD_CHECKSUM_EN
            load_checksum <= 32'd0;
`endif
          end
        end
        LOAD: begin
          if (ld_acc) begin
            ld_cnt <= ld_cnt + 1'b1;
`ifdef CHUNK_LOAD_CHECKSUM_EN
            load_checksum <= load_checksum + 32'(ddr_rd_data);
`endif
            if (ld_cnt == LAST_IDX) begin
              state         <= COMPUTE;
              compute_start <= 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (compute_done) begin
            state  <= STORE;
            rd_cnt <= '0;
            wr_cnt <= '0;
          end
        end
        STORE: begin
          if (issue) rd_cnt <= rd_cnt + 1'b1;
          if (pop) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == LAST_IDX) begin
              state       <= DONE;
              chunk_count <= chunk_count + 16'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Three-entry skid FIFO absorbing the one-cycle BRAM read latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1         <= 1'b0;
      fifo_wp    <= 2'd0;
      fifo_rp    <= 2'd0;
      fifo_count <= 2'd0;
      for (int i = 0; i < 3; i++) fifo_mem[i] <= '0;
    end else begin
      p1 <= issue;
      if (p1) begin
        fifo_mem[fifo_wp] <= bram_dout;
        fifo_wp           <= ptr_next(fifo_wp);
      end
      if (pop) fifo_rp <= ptr_next(fifo_rp);
      case ({p1, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_transfer_ctrl.sv
// Directed self-checking bench for chunk_transfer_ctrl with an 8-word chunk.
module tb_chunk_transfer_ctrl;
  localparam int DW = 32;
  localparam int AW = 12;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] ddr_rd_data = '0;
  logic          ddr_rd_valid = 1'b0;
  logic          ddr_rd_ready;
  logic [DW-1:0] ddr_wr_data;
  logic          ddr_wr_valid;
  logic          ddr_wr_ready = 1'b0;
  logic [DW-1:0] bram_dout = '0;
  logic [DW-1:0] bram_din;
  logic [AW-1:0] DDR_addr;
  logic          wen;
  logic          chunk_transfer_ready;
  logic          chunk_compute_ready;
  logic          compute_start;
  logic          compute_done = 1'b0;
  logic          busy;
  logic          chunk_done;
  logic [15:0]   chunk_count;
`ifdef CHUNK_LOAD_CHECKSUM_EN
  logic [31:0]   load_checksum;
`endif

  int total = 0;
  int bad   = 0;

  chunk_transfer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .CHUNK_WORDS(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .ddr_rd_data(ddr_rd_data), .ddr_rd_valid(ddr_rd_valid), .ddr_rd_ready(ddr_rd_ready),
    .ddr_wr_data(ddr_wr_data), .ddr_wr_valid(ddr_wr_valid), .ddr_wr_ready(ddr_wr_ready),
    .bram_dout(bram_dout), .bram_din(bram_din), .DDR_addr(DDR_addr), .wen(wen),
    .chunk_transfer_ready(chunk_transfer_ready), .chunk_compute_ready(chunk_compute_ready),
    .compute_start(compute_start), .compute_done(compute_done), .busy(busy),
    .chunk_done(chunk_done), .chunk_count(chunk_count)
`ifdef CHUNK_LOAD_CHECKSUM_EN
    , .load_checksum(load_checksum)
`endif
  );

  always #5 clk = ~clk;

  // BRAM model: data = address * 3, one cycle after the address.
  always @(posedge clk) bram_dout <= {20'd0, DDR_addr} * 32'd3;

  task automatic load_chunk();
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < CW; i++) begin
      @(negedge clk); start = 1'b0; ddr_rd_valid = 1'b1; ddr_rd_data = 32'h10 + 32'(i);
    end
    @(negedge clk); ddr_rd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++;
    if ({ddr_rd_ready, ddr_wr_valid, wen, chunk_transfer_ready, chunk_compute_ready,
         compute_start, busy, chunk_done, DDR_addr, bram_din, ddr_wr_data, chunk_count} !== '0) begin
      bad++; $display("FAIL reset_outputs busy=%b addr=%h count=%0d expected all zero", busy, DDR_addr, chunk_count);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_continuous();
    @(negedge clk); start = 1'b1;
    for (int i = 0; i < CW; i++) begin
      @(negedge clk); start = 1'b0; ddr_rd_valid = 1'b1; ddr_rd_data = 32'h10 + 32'(i);
      #1;
      total++;
      if (wen !== 1'b1 || DDR_addr !== AW'(i) || ddr_rd_ready !== 1'b1 || bram_din !== 32'h10 + 32'(i)) begin
        bad++; $display("FAIL load_cont[%0d] wen=%b addr=%0d din=%h expected wen=1 addr=%0d", i, wen, DDR_addr, bram_din, i);
      end
    end
    @(negedge clk); ddr_rd_valid = 1'b0; #1;
    total++;
    if (compute_start !== 1'b1 || chunk_compute_ready !== 1'b1) begin
      bad++; $display("FAIL compute_entry start=%b ready=%b expected 1 1", compute_start, chunk_compute_ready);
    end
    total++;
    if (wen !== 1'b0 || DDR_addr !== 12'd0 || chunk_transfer_ready !== 1'b0) begin
      bad++; $display("FAIL compute_idle_bus wen=%b addr=%0d xfer=%b expected 0 0 0", wen, DDR_addr, chunk_transfer_ready);
    end
`ifdef CHUNK_LOAD_CHECKSUM_EN
    total++;
    if (load_checksum !== 32'h9C) begin
      bad++; $display("FAIL checksum got=%h expected 0000009c", load_checksum);
    end
`endif
    @(negedge clk); #1;
    total++;
    if (compute_start !== 1'b0 || chunk_compute_ready !== 1'b1) begin
      bad++; $display("FAIL compute_pulse start=%b ready=%b expected 0 1", compute_start, chunk_compute_ready);
    end
  endtask

  task automatic test_store_continuous();
    int got = 0; int first_c = -1; int last_c = -1; bit done = 1'b0;
    @(negedge clk); compute_done = 1'b1; ddr_wr_ready = 1'b1;
    @(negedge clk); compute_done = 1'b0; #1;
    total++;
    if (chunk_transfer_ready !== 1'b1 || wen !== 1'b0 || chunk_compute_ready !== 1'b0) begin
      bad++; $display("FAIL store_entry xfer=%b wen=%b comp=%b expected 1 0 0", chunk_transfer_ready, wen, chunk_compute_ready);
    end
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      if (ddr_wr_valid && ddr_wr_ready) begin
        total++;
        if (ddr_wr_data !== 32'(got * 3)) begin
          bad++; $display("FAIL store_word[%0d] got=%0d expected %0d", got, ddr_wr_data, got * 3);
        end
        if (first_c < 0) first_c = c;
        last_c = c;
        got++;
      end
      if (chunk_done) done = 1'b1;
    end
    total++;
    if (!done || got != CW || (last_c - first_c) != CW - 1) begin
      bad++; $display("FAIL store_stream done=%b words=%0d span=%0d expected 1 8 7", done, got, last_c - first_c);
    end
    @(negedge clk); #1;
    total++;
    if (busy !== 1'b0 || chunk_count !== 16'd1 || chunk_done !== 1'b0) begin
      bad++; $display("FAIL after_chunk busy=%b count=%0d done=%b expected 0 1 0", busy, chunk_count, chunk_done);
    end
  endtask

  task automatic test_load_toggle();
    @(negedge clk); compute_done = 1'b1;
    @(negedge clk); compute_done = 1'b0; #1;
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_compute_done busy=%b expected 0", busy);
    end
    @(negedge clk); start = 1'b1;
    for (int k = 0; k < 2 * CW - 1; k++) begin
      @(negedge clk); start = 1'b0;
      ddr_rd_valid = (k % 2 == 0); ddr_rd_data = 32'h10 + 32'(k / 2); compute_done = (k == 3);
      #1;
      total++;
      if (wen !== ddr_rd_valid || DDR_addr !== AW'((k + 1) / 2) || chunk_transfer_ready !== 1'b1) begin
        bad++; $display("FAIL load_toggle[%0d] wen=%b addr=%0d xfer=%b expected wen=%b addr=%0d xfer=1",
                        k, wen, DDR_addr, chunk_transfer_ready, ddr_rd_valid, (k + 1) / 2);
      end
    end
    @(negedge clk); ddr_rd_valid = 1'b0; compute_done = 1'b0; #1;
    total++;
    if (chunk_compute_ready !== 1'b1 || compute_start !== 1'b1) begin
      bad++; $display("FAIL toggle_compute comp=%b start=%b expected 1 1", chunk_compute_ready, compute_start);
    end
  endtask

  task automatic test_store_backpressure();
    int got = 0; int stall = 0; bit done = 1'b0; logic [AW-1:0] held_addr = '0;
    @(negedge clk); compute_done = 1'b1; ddr_wr_ready = 1'b1;
    @(negedge clk); compute_done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(negedge clk);
      ddr_wr_ready = !(got == 2 && stall < 5);
      #1;
      if (!ddr_wr_ready) begin
        stall++;
        if (stall == 2) held_addr = DDR_addr;
        total++;
        if (ddr_wr_valid !== 1'b1 || ddr_wr_data !== 32'(got * 3)) begin
          bad++; $display("FAIL stall_hold[%0d] valid=%b data=%0d expected 1 %0d", stall, ddr_wr_valid, ddr_wr_data, got * 3);
        end
        if (stall > 2) begin
          total++;
          if (DDR_addr !== held_addr) begin
            bad++; $display("FAIL stall_issue[%0d] addr=%0d expected %0d", stall, DDR_addr, held_addr);
          end
        end
      end
      if (ddr_wr_valid && ddr_wr_ready) begin
        total++;
        if (ddr_wr_data !== 32'(got * 3)) begin
          bad++; $display("FAIL bp_word[%0d] got=%0d expected %0d", got, ddr_wr_data, got * 3);
        end
        got++;
      end
      if (chunk_done) done = 1'b1;
    end
    ddr_wr_ready = 1'b1;
    total++;
    if (!done || got != CW || stall != 5) begin
      bad++; $display("FAIL bp_stream done=%b words=%0d stalls=%0d expected 1 8 5", done, got, stall);
    end
    @(negedge clk); #1;
    total++;
    if (chunk_count !== 16'd2 || busy !== 1'b0) begin
      bad++; $display("FAIL bp_count count=%0d busy=%b expected 2 0", chunk_count, busy);
    end
  endtask

  task automatic test_reset_mid_store();
    int got = 0; bit done = 1'b0;
    load_chunk();
    @(negedge clk); compute_done = 1'b1; ddr_wr_ready = 1'b1;
    @(negedge clk); compute_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk); #1;
      if (ddr_wr_valid && got == 4) break;
      if (ddr_wr_valid && ddr_wr_ready) got++;
    end
    rst_n = 1'b0; #1;
    total++;
    if ({ddr_rd_ready, ddr_wr_valid, wen, chunk_transfer_ready, chunk_compute_ready,
         compute_start, busy, chunk_done, DDR_addr, bram_din, ddr_wr_data, chunk_count} !== '0) begin
      bad++; $display("FAIL mid_reset busy=%b valid=%b addr=%0d count=%0d expected all zero", busy, ddr_wr_valid, DDR_addr, chunk_count);
    end
    @(negedge clk); rst_n = 1'b1; ddr_wr_ready = 1'b0;
    load_chunk();
`ifdef CHUNK_LOAD_CHECKSUM_EN
    #1;
    total++;
    if (load_checksum !== 32'h9C) begin
      bad++; $display("FAIL post_reset_checksum got=%h expected 0000009c", load_checksum);
    end
`endif
    got = 0;
    @(negedge clk); compute_done = 1'b1; ddr_wr_ready = 1'b1;
    @(negedge clk); compute_done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk); #1;
      if (ddr_wr_valid && ddr_wr_ready) begin
        total++;
        if (ddr_wr_data !== 32'(got * 3)) begin
          bad++; $display("FAIL clean_word[%0d] got=%0d expected %0d", got, ddr_wr_data, got * 3);
        end
        got++;
      end
      if (chunk_done) done = 1'b1;
    end
    @(negedge clk); #1;
    total++;
    if (!done || got != CW || chunk_count !== 16'd1) begin
      bad++; $display("FAIL clean_chunk done=%b words=%0d count=%0d expected 1 8 1", done, got, chunk_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_continuous();
    test_store_continuous();
    test_load_toggle();
    test_store_backpressure();
    test_reset_mid_store();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chunk_transfer_ctrl.md
Name: chunk_transfer_ctrl

Overview:
- Sequencer directly upstream of the BRAM address toggle.
- Per chunk: loads CHUNK_WORDS words from the DDR read stream into chunk BRAM, hands BRAM to the LBM compute core, then streams the chunk back to DDR.
- Produces the chunk_transfer_ready / chunk_compute_ready phase flags, the DDR-side BRAM address and wen consumed by the address toggle, and the DDR stream handshakes.

Parameters:
- DATA_W, 32, width of DDR/BRAM data words
- ADDR_W, 12, BRAM address width
- CHUNK_WORDS, 4096, words per chunk; legal range 2..2^ADDR_W

Ports:
- clk  in  1  single clock domain; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one chunk cycle; sampled only in IDLE
- ddr_rd_data  in  DATA_W  load-stream word
- ddr_rd_valid  in  1  load-stream word valid
- ddr_rd_ready  out  1  load-stream accept
- ddr_wr_data  out  DATA_W  store-stream word
- ddr_wr_valid  out  1  store-stream word valid
- ddr_wr_ready  in  1  store-stream accept
- bram_dout  in  DATA_W  BRAM read data, 1-cycle latency after address
- bram_din  out  DATA_W  BRAM write data
- DDR_addr  out  ADDR_W  DDR-side BRAM address to the toggle
- wen  out  1  BRAM write enable, DDR side
- chunk_transfer_ready  out  1  high in LOAD and STORE
- chunk_compute_ready  out  1  high in COMPUTE
- compute_start  out  1  one-cycle pulse on entry to COMPUTE
- compute_done  in  1  LBM core finished the chunk
- busy  out  1  state != IDLE
- chunk_done  out  1  one-cycle pulse in DONE
- chunk_count  out  16  completed chunks, wraps at 2^16

Behaviour:
- States: IDLE, LOAD, COMPUTE, STORE, DONE.
- Reset values: state IDLE, all counters 0, FIFO empty, every output 0.
- Transitions:
  - IDLE to LOAD on start.
  - LOAD to COMPUTE after the CHUNK_WORDS-th word is accepted.
  - COMPUTE to STORE on compute_done.
  - STORE to DONE after the CHUNK_WORDS-th word is accepted on the write stream.
  - DONE to IDLE unconditionally.
- start outside IDLE is ignored. compute_done outside COMPUTE is ignored.
- LOAD, zero latency (combinational):
  - ddr_rd_ready=1.
  - wen = ddr_rd_valid.
  - DDR_addr = ld_cnt.
  - bram_din = ddr_rd_data.
  - ld_cnt increments per accepted word; up to 1 word/cycle.
- COMPUTE:
  - compute_start is registered and high for the first COMPUTE cycle only.
  - DDR_addr holds 0; wen=0.
- STORE:
  - Read issue counter rd_cnt drives DDR_addr; wen=0.
  - A read issues when rd_cnt < CHUNK_WORDS and (fifo_count + p1) < 3.
  - p1 flags an issue in the previous cycle.
  - When p1 is set, bram_dout is pushed into a 3-entry FIFO.
  - ddr_wr_valid = FIFO non-empty; ddr_wr_data = FIFO head.
  - A pop occurs on valid&ready; wr_cnt counts pops.
  - Sustains 1 word/cycle under continuous ddr_wr_ready.
  - Simultaneous push and pop on a full FIFO is legal: count unchanged.
  - ddr_wr_valid, once high, holds with stable data until accepted.
- Counter widths: ADDR_W+1 bits, so CHUNK_WORDS=2^ADDR_W terminates correctly. All counters clear on entering LOAD/STORE.
- Phase flags and busy are decoded from registered state, so they are glitch-free.
- chunk_done: high for the single DONE cycle. chunk_count increments in the same cycle.
- Reset mid-operation:
  - Abandons the chunk immediately; state returns to IDLE and the FIFO flushes.
  - chunk_count is cleared.
  - No partial chunk_done is produced.

Optional Feature:
- Macro: CHUNK_LOAD_CHECKSUM_EN.
- Defined:
  - Adds output load_checksum [31:0], the modulo-2^32 sum of all words accepted in LOAD (zero-extended or truncated to 32 bits).
  - Cleared on entering LOAD; stable from COMPUTE until the next LOAD; reset to 0.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- CHUNK_WORDS=8, start, ddr_rd_valid continuous with data 0x10..0x17 -> wen high 8 consecutive cycles, DDR_addr 0..7; compute_start pulses the next cycle; chunk_compute_ready=1.
- LOAD with ddr_rd_valid toggled 1,0,1,0... -> wen follows valid; addresses still 0..7 with no gaps or repeats; COMPUTE only after word 8.
- compute_done pulsed during LOAD and IDLE -> ignored. Then pulsed in COMPUTE -> STORE next cycle with chunk_transfer_ready=1.
- STORE with BRAM model returning addr*3, ddr_wr_ready=1 -> 8 words 0,3..21 in 8 consecutive valid cycles. Then chunk_done pulse, chunk_count=1, busy=0.
- STORE with ddr_wr_ready low 5 cycles mid-stream -> FIFO fills to 3, issue stalls, data held stable; resumes; no loss or duplication; order preserved.
- rst_n low during STORE word 4 -> all outputs 0 asynchronously. A new start then runs a full clean chunk with chunk_count=1. With CHUNK_LOAD_CHECKSUM_EN, load_checksum=0x9C for data 0x10..0x17.
